// File: rtl/mod_product_seq.sv
// ---------------------------------------------------------------------------
// mod_product_seq
// Sequential modular multiplier: result = (a * b) mod N, computed with a
// shift-and-add loop that consumes one bit of `a` (LSB first) per clock.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous, active-high reset
//   start_i   request; operands sampled on the edge where start_i=1 in IDLE
//   abort_i   cancel a running operation (CALC only), no done pulse
//   n_i       modulus, 1 < N < 2^W
//   a_i       multiplier, scanned LSB first
//   b_i       multiplicand, b < N
//   k_i       index of the last bit of a processed (k+1 iterations)
//   busy_o    high while the loop is running
//   done_o    one-cycle pulse when result_o is updated
//   result_o  last completed product, held until the next completion
//
// Build option
//   MODPROD_EARLY_TERM_EN : when defined, the loop stops as soon as no set
//   bit of `a` remains above the current position (data-dependent latency).
//   When undefined the loop always runs k+1 iterations (constant time).
// ---------------------------------------------------------------------------
module mod_product_seq #(
  parameter int W   = 256,
  parameter int K_W = 11
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [W-1:0]   n_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [K_W-1:0] k_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [W-1:0]   result_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q,  state_d;
  logic [W-1:0]   n_q,      n_d;
  logic [W-1:0]   a_q,      a_d;      // shifted right each iteration; bit 0 is the current bit
  logic [K_W-1:0] k_q,      k_d;
  logic [K_W-1:0] i_q,      i_d;
  logic [W:0]     t_q,      t_d;      // b * 2^i mod N
  logic [W:0]     m_q,      m_d;      // partial product mod N
  logic           busy_q,   busy_d;
  logic           done_q,   done_d;
  logic [W-1:0]   result_q, result_d;

  logic [W+1:0]   n_ext_s;
  logic [W+1:0]   sum_s;
  logic [W+1:0]   dbl_s;
  logic [W:0]     m_step_s;
  logic [W:0]     t_step_s;
  logic           last_s;

  // One loop iteration: conditional add-reduce of m and double-reduce of t.
  always_comb begin
    n_ext_s = {2'b00, n_q};
    sum_s   = {1'b0, m_q} + {1'b0, t_q};
    dbl_s   = {1'b0, t_q, 1'b0};
    // Both operands are below N, so a reduced value always fits in W+1 bits.
    if (a_q[0]) begin
      if (sum_s >= n_ext_s) begin
        m_step_s = sum_s[W:0] - {1'b0, n_q};
      end else begin
        m_step_s = sum_s[W:0];
      end
    end else begin
      m_step_s = m_q;
    end
    if (dbl_s >= n_ext_s) begin
      t_step_s = dbl_s[W:0] - {1'b0, n_q};
    end else begin
      t_step_s = dbl_s[W:0];
    end
`ifdef MODPROD_EARLY_TERM_EN
    // a_q[W-1:1] holds the bits above the current position.
    last_s = (i_q == k_q) || (a_q[W-1:1] == {(W-1){1'b0}});
`else
    last_s = (i_q == k_q);
`endif
  end

  // Control FSM and next-state values for all registers.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    k_d      = k_q;
    i_d      = i_q;
    t_d      = t_q;
    m_d      = m_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CALC;
          n_d     = n_i;
          a_d     = a_i;
          k_d     = k_i;
          i_d     = {K_W{1'b0}};
          t_d     = {1'b0, b_i};
          m_d     = {(W+1){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // Abort wins over a completion on the same edge.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          m_d = m_step_s;
          t_d = t_step_s;
          a_d = {1'b0, a_q[W-1:1]};   // positions >= W read as zero
          i_d = i_q + {{(K_W-1){1'b0}}, 1'b1};
          if (last_s) begin
            state_d  = ST_DONE;
            result_d = m_step_s[W-1:0];
            done_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CALC);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      n_q      <= {W{1'b0}};
      a_q      <= {W{1'b0}};
      k_q      <= {K_W{1'b0}};
      i_q      <= {K_W{1'b0}};
      t_q      <= {(W+1){1'b0}};
      m_q      <= {(W+1){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {W{1'b0}};
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      k_q      <= k_d;
      i_q      <= i_d;
      t_q      <= t_d;
      m_q      <= m_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mod_product_seq.sv
// ---------------------------------------------------------------------------
// tb_mod_product_seq
// Self-checking bench: a W=8 instance is checked every cycle against a
// transaction-level model (arithmetic product + latency countdown), and
// directed jobs pin results and latencies to hand-computed literals.
// A W=256 instance runs the wide-operand jobs with literal expectations.
// ---------------------------------------------------------------------------
module tb_mod_product_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [7:0]  n = 8'd13, a = 8'd0, b = 8'd0;
  logic [10:0] k = 11'd0;
  logic        busy, done;
  logic [7:0]  result;

  logic          start2 = 1'b0, abort2 = 1'b0;
  logic [255:0]  n2 = 256'd0, a2 = 256'd0, b2 = 256'd0;
  logic [10:0]   k2 = 11'd0;
  logic          busy2, done2;
  logic [255:0]  result2;

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  mod_product_seq #(.W(8), .K_W(11)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .n_i(n), .a_i(a), .b_i(b), .k_i(k),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  mod_product_seq #(.W(256), .K_W(11)) dut256 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort2),
    .n_i(n2), .a_i(a2), .b_i(b2), .k_i(k2),
    .busy_o(busy2), .done_o(done2), .result_o(result2)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: only bits 0..k of a contribute; plain multiply then modulo.
  function automatic logic [7:0] ref_modmul(input logic [7:0] nn, input logic [7:0] aa,
                                            input logic [7:0] bb, input logic [10:0] kk);
    logic [15:0] am;
    logic [15:0] prod;
    am = {8'd0, aa};
    if (kk < 11'd7) am = am & ((16'd1 << (kk + 11'd1)) - 16'd1);
    prod = am * {8'd0, bb};
    return 8'(prod % {8'd0, nn});
  endfunction

  function automatic int ref_lat(input logic [7:0] aa, input logic [10:0] kk);
    int top;
    top = 0;
    for (int j = 0; j < 8; j++) if (aa[j]) top = j;
`ifdef MODPROD_EARLY_TERM_EN
    return ((int'(kk) < top) ? int'(kk) : top) + 1;
`else
    return int'(kk) + 1;
`endif
  endfunction

  // Transaction-level model of the W=8 instance.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_result = 8'd0;
  logic [7:0] m_pending = 8'd0;
  int         m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_result  <= 8'd0;
      m_pending <= 8'd0;
      m_left    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (abort) begin
          m_busy <= 1'b0;
        end else if (m_left == 0) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_result <= m_pending;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (!m_done && start) begin
        m_busy    <= 1'b1;
        m_left    <= ref_lat(a, k) - 1;
        m_pending <= ref_modmul(n, a, b, k);
      end
    end
  end

  // Per-cycle comparison of the W=8 instance against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", {255'd0, busy}, {255'd0, m_busy});
      check("model_done", {255'd0, done}, {255'd0, m_done});
      check("model_result", {248'd0, result}, {248'd0, m_result});
    end
  end

  task automatic run8(input logic [7:0] nn, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [10:0] kk, input logic with_abort, input logic [7:0] exp_res,
                      input int lat_off, input int lat_on, input string name);
    int cyc;
    logic got;
    int exp_lat;
`ifdef MODPROD_EARLY_TERM_EN
    exp_lat = lat_on;
`else
    exp_lat = lat_off;
`endif
    n = nn; a = aa; b = bb; k = kk; start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    // operands change after acceptance and must not matter
    n = ~nn; a = ~aa; b = ~bb; k = 11'd3;
    cyc = 0; got = 1'b0;
    while (cyc < 400 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check({name, "_lat"}, 256'(cyc), 256'(exp_lat));
    check({name, "_res"}, {248'd0, result}, {248'd0, exp_res});
    @(posedge clk); #1;
  endtask

  task automatic run256(input logic [255:0] aa, input logic [255:0] bb, input logic [10:0] kk,
                        input logic [255:0] exp_res, input int lat_off, input int lat_on,
                        input string name);
    int cyc;
    logic got;
    int exp_lat;
`ifdef MODPROD_EARLY_TERM_EN
    exp_lat = lat_on;
`else
    exp_lat = lat_off;
`endif
    a2 = aa; b2 = bb; k2 = kk; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check({name, "_busy"}, {255'd0, busy2}, 256'd1);
    cyc = 0; got = 1'b0;
    while (cyc < 400 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done2) got = 1'b1;
    end
    check({name, "_lat"}, 256'(cyc), 256'(exp_lat));
    check({name, "_res"}, result2, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    logic seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_busy", {255'd0, busy}, 256'd0);
    check("reset_done", {255'd0, done}, 256'd0);
    check("reset_result", {248'd0, result}, 256'd0);
    check("reset_result256", result2, 256'd0);

    run8(8'd13,  8'd7,   8'd9,   11'd7,  1'b0, 8'd11,  8,  3, "basic");
    run8(8'd251, 8'd250, 8'd250, 11'd7,  1'b0, 8'd1,   8,  8, "n251");
    run8(8'd13,  8'd7,   8'd9,   11'd0,  1'b0, 8'd9,   1,  1, "k0");
    run8(8'd13,  8'd7,   8'd9,   11'd1,  1'b0, 8'd1,   2,  2, "k1");
    run8(8'd13,  8'd0,   8'd5,   11'd7,  1'b0, 8'd0,   8,  1, "a0");
    run8(8'd13,  8'd7,   8'd9,   11'd20, 1'b0, 8'd11, 21,  3, "k_above_w");
    run8(8'd13,  8'd5,   8'd4,   11'd3,  1'b1, 8'd7,   4,  3, "start_abort");
    run8(8'd254, 8'd255, 8'd253, 11'd7,  1'b0, 8'd253, 8,  8, "wide_sum");

    // abort at cycle 4: back to IDLE, no done, previous result kept
    n = 8'd13; a = 8'd135; b = 8'd9; k = 11'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", {255'd0, busy}, 256'd0);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("abort_no_done", {255'd0, seen}, 256'd0);
    check("abort_result_kept", {248'd0, result}, 256'd253);
    // abort while idle has no effect
    abort = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b0;
    run8(8'd13, 8'd7, 8'd9, 11'd7, 1'b0, 8'd11, 8, 3, "after_abort");

    // start during CALC with other operands is ignored
    run8(8'd251, 8'd250, 8'd250, 11'd7, 1'b0, 8'd1, 8, 8, "prep");
    n = 8'd13; a = 8'd7; b = 8'd9; k = 11'd7; start = 1'b1;
    @(posedge clk); #1;
    n = 8'd251; a = 8'd250; b = 8'd250;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 2; seen = 1'b0;
    while (cyc < 400 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
`ifdef MODPROD_EARLY_TERM_EN
    check("ignore_start_lat", 256'(cyc), 256'd3);
`else
    check("ignore_start_lat", 256'(cyc), 256'd8);
`endif
    check("ignore_start_res", {248'd0, result}, 256'd11);
    repeat (2) begin @(posedge clk); #1; end

    // asynchronous reset in the middle of a job
    n = 8'd13; a = 8'd7; b = 8'd9; k = 11'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {255'd0, busy}, 256'd0);
    check("rst_mid_done", {255'd0, done}, 256'd0);
    check("rst_mid_result", {248'd0, result}, 256'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("rst_mid_no_done", {255'd0, seen}, 256'd0);
    run8(8'd251, 8'd250, 8'd250, 11'd7, 1'b0, 8'd1, 8, 8, "after_rst");

    // wide operands: N = 2^255 + 95
    n2 = (256'd1 << 255) + 256'd95;
    run256(256'd0, 256'd5, 11'd255, 256'd0, 256, 1, "w256_a0");
    run256(256'd2, (256'd1 << 255) + 256'd94, 11'd255, (256'd1 << 255) + 256'd93, 256, 2, "w256_nm2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
